decode_regread: RTL and testbench

- Decode/operand-fetch stage directly upstream of the execute stage.
- Accepts pc/inst from fetch over a valid/ready handshake and reads rs1/rs2 from an internal 32x32 register file.
- Blocks RAW/WAW hazards with a per-register busy scoreboard and presents a registered pc/inst/r0data/r1data bundle to execute.
- Takes the writeback port from the downstream stage and a flush from execute's jump-taken signal.

---
 rtl/decode_regread_pkg.sv | 64 ++++++
 rtl/decode_regread_regfile_2r1w.sv | 66 ++++++
 rtl/decode_regread.sv | 144 ++++++++++++++
 tb/tb_decode_regread.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_regread_pkg.sv
// -----------------------------------------------------------------------------
// decode_regread_pkg
// Shared instruction-set definitions for the decode and execute stages:
// datapath sizes, RV32 base opcodes, instruction field bit ranges, and the
// decode classifier functions (which source registers an instruction reads
// and whether it writes a destination register).
// -----------------------------------------------------------------------------
package decode_regread_pkg;

    localparam int PKG_XLEN  = 32;
    localparam int PKG_NREG  = 32;
    localparam int REG_IDX_W = 5;

    // Instruction field bit ranges
    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;

    // RV32I base opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Instruction reads rs1
    function automatic logic uses_rs1(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_JALR,
            OPC_LOAD, OPC_STORE, OPC_BRANCH: uses_rs1 = 1'b1;
            default:                         uses_rs1 = 1'b0;
        endcase
    endfunction

    // Instruction reads rs2
    function automatic logic uses_rs2(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_STORE, OPC_BRANCH: uses_rs2 = 1'b1;
            default:                       uses_rs2 = 1'b0;
        endcase
    endfunction

    // Instruction produces an architectural result; x0 destinations never count
    function automatic logic writes_rd(input logic [6:0] opc,
                                       input logic [REG_IDX_W-1:0] rd);
        logic wr;
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
            OPC_JAL, OPC_JALR, OPC_LOAD: wr = 1'b1;
            default:                     wr = 1'b0;
        endcase
        writes_rd = wr && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/decode_regread_regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
// Architectural register file: two asynchronous read ports, one synchronous
// write port. x0 always reads zero and is never written. A read of the
// register being written in the same cycle returns the write data
// (write-through), so decode sees writeback results without a bubble.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset (clears all regs)
//   raddr0/raddr1    read addresses
//   rdata0/rdata1    read data (combinational)
//   we, waddr, wdata write enable / address / data
// -----------------------------------------------------------------------------
module regfile_2r1w
    import decode_regread_pkg::*;
#(
    parameter int XLEN = PKG_XLEN,
    parameter int NREG = PKG_NREG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] raddr0,
    input  logic [REG_IDX_W-1:0] raddr1,
    output logic [XLEN-1:0]      rdata0,
    output logic [XLEN-1:0]      rdata1,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [XLEN-1:0]      wdata
);

    logic [XLEN-1:0] regs_r [NREG];

    // Register storage: cleared on reset, writes to x0 dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs_r[waddr] <= wdata;
        end
    end

    // Read port 0 with x0 and write-through handling
    always_comb begin
        if (raddr0 == 5'd0) begin
            rdata0 = '0;
        end else if (we && (waddr == raddr0)) begin
            rdata0 = wdata;
        end else begin
            rdata0 = regs_r[raddr0];
        end
    end

    // Read port 1 with x0 and write-through handling
    always_comb begin
        if (raddr1 == 5'd0) begin
            rdata1 = '0;
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = regs_r[raddr1];
        end
    end

endmodule

// File: rtl/decode_regread.sv
// -----------------------------------------------------------------------------
// decode_regread
// Decode / operand-fetch stage in front of execute. Accepts pc/inst from fetch
// over valid/ready, reads rs1/rs2 from the register file, blocks RAW/WAW
// hazards with a per-register busy scoreboard, and presents a registered
// pc/inst/r0data/r1data bundle to execute.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   valid_i, ready_o, pc_i, inst_i   fetch handshake and bundle
//   valid_ro, ready_i                execute handshake
//   pc_ro, inst_ro, r0data_ro,
//   r1data_ro                        registered bundle to execute
//   flush_i                          jump taken in execute; drops the fetch bundle
//   wb_en_i, wb_rd_i, wb_data_i      writeback port (never backpressured)
//   stall_o                          hazard stall indicator
// -----------------------------------------------------------------------------
module decode_regread
    import decode_regread_pkg::*;
#(
    parameter int XLEN = PKG_XLEN,
    parameter int NREG = PKG_NREG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [31:0]          pc_i,
    input  logic [31:0]          inst_i,
    output logic                 valid_ro,
    input  logic                 ready_i,
    output logic [31:0]          pc_ro,
    output logic [31:0]          inst_ro,
    output logic [XLEN-1:0]      r0data_ro,
    output logic [XLEN-1:0]      r1data_ro,
    input  logic                 flush_i,
    input  logic                 wb_en_i,
    input  logic [REG_IDX_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0]      wb_data_i,
    output logic                 stall_o
);

    logic [6:0]           opcode_s;
    logic [REG_IDX_W-1:0] rd_s;
    logic [REG_IDX_W-1:0] rs1_s;
    logic [REG_IDX_W-1:0] rs2_s;
    logic                 use_rs1_s;
    logic                 use_rs2_s;
    logic                 wr_rd_s;

    logic [NREG-1:0]      busy_r;
    logic [NREG-1:0]      busy_nxt_s;
    logic [NREG-1:0]      wb_clr_s;
    logic [NREG-1:0]      eff_busy_s;

    logic                 hazard_s;
    logic                 cke_s;
    logic                 issue_s;
    logic [XLEN-1:0]      rdata0_s;
    logic [XLEN-1:0]      rdata1_s;

    assign opcode_s  = inst_i[OPC_MSB:OPC_LSB];
    assign rd_s      = inst_i[RD_MSB:RD_LSB];
    assign rs1_s     = inst_i[RS1_MSB:RS1_LSB];
    assign rs2_s     = inst_i[RS2_MSB:RS2_LSB];
    assign use_rs1_s = uses_rs1(opcode_s);
    assign use_rs2_s = uses_rs2(opcode_s);
    assign wr_rd_s   = writes_rd(opcode_s, rd_s);

    // One-hot of the register being written back this cycle
    always_comb begin
        wb_clr_s = '0;
        for (int r = 0; r < NREG; r++) begin
            wb_clr_s[r] = wb_en_i && (wb_rd_i == REG_IDX_W'(r));
        end
    end

    // A register retiring this cycle is no longer a hazard: its value is
    // forwarded by the register file's write-through path.
    assign eff_busy_s = busy_r & ~wb_clr_s;

    assign hazard_s = valid_i && ((use_rs1_s && eff_busy_s[rs1_s]) ||
                                  (use_rs2_s && eff_busy_s[rs2_s]) ||
                                  (wr_rd_s   && eff_busy_s[rd_s]));

    assign cke_s   = !valid_ro || ready_i;
    assign issue_s = valid_i && cke_s && !hazard_s && !flush_i;
    // During a flush the fetch bundle is consumed even if it would stall.
    assign ready_o = cke_s && (!hazard_s || flush_i);
    assign stall_o = valid_i && cke_s && hazard_s && !flush_i;

    regfile_2r1w #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr0 (rs1_s),
        .raddr1 (rs2_s),
        .rdata0 (rdata0_s),
        .rdata1 (rdata1_s),
        .we     (wb_en_i),
        .waddr  (wb_rd_i),
        .wdata  (wb_data_i)
    );

    // Scoreboard next state: clear on writeback, then set on issue (set wins)
    always_comb begin
        busy_nxt_s = busy_r & ~wb_clr_s;
        if (issue_s && wr_rd_s) begin
            busy_nxt_s[rd_s] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Output pipeline register; data fields load whenever the stage advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_ro  <= 1'b0;
            pc_ro     <= 32'd0;
            inst_ro   <= 32'd0;
            r0data_ro <= '0;
            r1data_ro <= '0;
        end else if (cke_s) begin
            valid_ro  <= issue_s;
            pc_ro     <= pc_i;
            inst_ro   <= inst_i;
            r0data_ro <= rdata0_s;
            r1data_ro <= rdata1_s;
        end
    end

endmodule

// File: tb/tb_decode_regread.sv
// -----------------------------------------------------------------------------
// tb_decode_regread
// Directed bench for decode_regread: reset state, single issue and writeback,
// RAW stall with writeback forwarding, backpressure hold, flush discard, x0
// handling, simultaneous writeback/issue on the same register, register file
// read-back, and reset in mid-operation.
// -----------------------------------------------------------------------------
module tb_decode_regread;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        valid_ro;
    logic        ready_i;
    logic [31:0] pc_ro;
    logic [31:0] inst_ro;
    logic [31:0] r0data_ro;
    logic [31:0] r1data_ro;
    logic        flush_i;
    logic        wb_en_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        stall_o;

    int n_checks;
    int n_fail;

    decode_regread dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .pc_i      (pc_i),
        .inst_i    (inst_i),
        .valid_ro  (valid_ro),
        .ready_i   (ready_i),
        .pc_ro     (pc_ro),
        .inst_ro   (inst_ro),
        .r0data_ro (r0data_ro),
        .r1data_ro (r1data_ro),
        .flush_i   (flush_i),
        .wb_en_i   (wb_en_i),
        .wb_rd_i   (wb_rd_i),
        .wb_data_i (wb_data_i),
        .stall_o   (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-encoded instructions
    localparam logic [31:0] ADDI_X1_X0_5  = 32'h0050_0093;
    localparam logic [31:0] ADD_X2_X1_X1  = 32'h0010_8133;
    localparam logic [31:0] ADDI_X6_X0_7  = 32'h0070_0313;
    localparam logic [31:0] ADDI_X8_X0_1  = 32'h0010_0413;
    localparam logic [31:0] ADDI_X3_X0_1  = 32'h0010_0193;
    localparam logic [31:0] ADD_X4_X0_X0  = 32'h0000_0233;
    localparam logic [31:0] ADDI_X5_X0_9  = 32'h0090_0293;
    localparam logic [31:0] ADDI_X5_X5_1  = 32'h0012_8293;
    localparam logic [31:0] ADD_X10_X5_X6 = 32'h0062_8533;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] busy_bit(input int i);
        return {31'd0, dut.busy_r[i]};
    endfunction

    // Apply a full input vector just after the falling edge, then let it settle
    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic [31:0] inst, input logic rdy,
                         input logic fl, input logic we,
                         input logic [4:0] wr, input logic [31:0] wd);
        @(negedge clk);
        valid_i   = v;
        pc_i      = pc;
        inst_i    = inst;
        ready_i   = rdy;
        flush_i   = fl;
        wb_en_i   = we;
        wb_rd_i   = wr;
        wb_data_i = wd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        valid_i   = 1'b0;
        pc_i      = 32'd0;
        inst_i    = 32'd0;
        ready_i   = 1'b1;
        flush_i   = 1'b0;
        wb_en_i   = 1'b0;
        wb_rd_i   = 5'd0;
        wb_data_i = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        check_eq("rst_valid_ro", {31'd0, valid_ro}, 32'd0);
        check_eq("rst_pc_ro", pc_ro, 32'd0);
        check_eq("rst_inst_ro", inst_ro, 32'd0);
        check_eq("rst_r0data", r0data_ro, 32'd0);
        check_eq("rst_r1data", r1data_ro, 32'd0);
        check_eq("rst_busy", dut.busy_r, 32'd0);
        check_eq("rst_ready_o", {31'd0, ready_o}, 32'd1);

        // Single issue: addi x1,x0,5
        drive(1'b1, 32'h100, ADDI_X1_X0_5, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check_eq("iss_ready_o", {31'd0, ready_o}, 32'd1);
        check_eq("iss_stall_o", {31'd0, stall_o}, 32'd0);
        tick();
        check_eq("iss_valid_ro", {31'd0, valid_ro}, 32'd1);
        check_eq("iss_inst_ro", inst_ro, ADDI_X1_X0_5);
        check_eq("iss_pc_ro", pc_ro, 32'h100);
        check_eq("iss_busy1", busy_bit(1), 32'd1);

        // RAW: add x2,x1,x1 while x1 in flight
        drive(1'b1, 32'h104, ADD_X2_X1_X1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check_eq("raw_stall_o", {31'd0, stall_o}, 32'd1);
        check_eq("raw_ready_o", {31'd0, ready_o}, 32'd0);
        tick();
        check_eq("raw_bubble_valid", {31'd0, valid_ro}, 32'd0);
        // Writeback of x1=5 in the same cycle releases and forwards
        drive(1'b1, 32'h104, ADD_X2_X1_X1, 1'b1, 1'b0, 1'b1, 5'd1, 32'd5);
        check_eq("rawwb_stall_o", {31'd0, stall_o}, 32'd0);
        check_eq("rawwb_ready_o", {31'd0, ready_o}, 32'd1);
        tick();
        check_eq("rawwb_valid_ro", {31'd0, valid_ro}, 32'd1);
        check_eq("rawwb_inst_ro", inst_ro, ADD_X2_X1_X1);
        check_eq("rawwb_r0data", r0data_ro, 32'd5);
        check_eq("rawwb_r1data", r1data_ro, 32'd5);
        check_eq("rawwb_busy1", busy_bit(1), 32'd0);
        check_eq("rawwb_busy2", busy_bit(2), 32'd1);

        // Retire x2
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd2, 32'd10);
        tick();
        check_eq("wb2_valid_ro", {31'd0, valid_ro}, 32'd0);
        check_eq("wb2_busy2", busy_bit(2), 32'd0);

        // Backpressure: load addi x6, then hold for 3 cycles
        drive(1'b1, 32'h200, ADDI_X6_X0_7, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        check_eq("bp_load_valid", {31'd0, valid_ro}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h204, ADDI_X8_X0_1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
            check_eq("bp_ready_o", {31'd0, ready_o}, 32'd0);
            check_eq("bp_stall_o", {31'd0, stall_o}, 32'd0);
            tick();
            check_eq("bp_valid_ro", {31'd0, valid_ro}, 32'd1);
            check_eq("bp_inst_ro", inst_ro, ADDI_X6_X0_7);
            check_eq("bp_pc_ro", pc_ro, 32'h200);
        end
        drive(1'b1, 32'h204, ADDI_X8_X0_1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check_eq("bprel_ready_o", {31'd0, ready_o}, 32'd1);
        tick();
        check_eq("bprel_valid_ro", {31'd0, valid_ro}, 32'd1);
        check_eq("bprel_inst_ro", inst_ro, ADDI_X8_X0_1);
        check_eq("bprel_pc_ro", pc_ro, 32'h204);
        check_eq("bprel_busy8", busy_bit(8), 32'd1);

        // Flush with addi x3 presented; writeback of x6 still honoured
        drive(1'b1, 32'h300, ADDI_X3_X0_1, 1'b1, 1'b1, 1'b1, 5'd6, 32'h66);
        check_eq("fl_ready_o", {31'd0, ready_o}, 32'd1);
        check_eq("fl_stall_o", {31'd0, stall_o}, 32'd0);
        tick();
        check_eq("fl_valid_ro", {31'd0, valid_ro}, 32'd0);
        check_eq("fl_busy3", busy_bit(3), 32'd0);
        check_eq("fl_busy6", busy_bit(6), 32'd0);

        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd8, 32'h88);
        tick();
        check_eq("wb8_busy8", busy_bit(8), 32'd0);

        // x0: write attempt ignored, then add x4,x0,x0
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF);
        tick();
        check_eq("x0wb_busy", dut.busy_r, 32'd0);
        drive(1'b1, 32'h400, ADD_X4_X0_X0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check_eq("x0_stall_o", {31'd0, stall_o}, 32'd0);
        check_eq("x0_ready_o", {31'd0, ready_o}, 32'd1);
        tick();
        check_eq("x0_valid_ro", {31'd0, valid_ro}, 32'd1);
        check_eq("x0_r0data", r0data_ro, 32'd0);
        check_eq("x0_r1data", r1data_ro, 32'd0);

        // Simultaneous: x5 in flight, writeback x5 while addi x5,x5,1 issues
        drive(1'b1, 32'h500, ADDI_X5_X0_9, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        check_eq("sim_pre_busy5", busy_bit(5), 32'd1);
        drive(1'b1, 32'h504, ADDI_X5_X5_1, 1'b1, 1'b0, 1'b1, 5'd5, 32'd9);
        check_eq("sim_stall_o", {31'd0, stall_o}, 32'd0);
        check_eq("sim_ready_o", {31'd0, ready_o}, 32'd1);
        tick();
        check_eq("sim_valid_ro", {31'd0, valid_ro}, 32'd1);
        check_eq("sim_r0data", r0data_ro, 32'd9);
        check_eq("sim_busy5", busy_bit(5), 32'd1);

        // Retire x5=10, then read x5 and x6 from the register file
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5, 32'd10);
        tick();
        check_eq("wb5_busy5", busy_bit(5), 32'd0);
        drive(1'b1, 32'h600, ADD_X10_X5_X6, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check_eq("rf_stall_o", {31'd0, stall_o}, 32'd0);
        tick();
        check_eq("rf_valid_ro", {31'd0, valid_ro}, 32'd1);
        check_eq("rf_r0data", r0data_ro, 32'd10);
        check_eq("rf_r1data", r1data_ro, 32'h66);
        check_eq("rf_busy10", busy_bit(10), 32'd1);

        // Reset mid-operation discards in-flight state
        @(negedge clk);
        valid_i = 1'b0;
        wb_en_i = 1'b0;
        rst     = 1'b1;
        #1;
        check_eq("mrst_valid_ro", {31'd0, valid_ro}, 32'd0);
        check_eq("mrst_busy", dut.busy_r, 32'd0);
        check_eq("mrst_r0data", r0data_ro, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        // x5 was cleared by reset
        drive(1'b1, 32'h700, ADD_X10_X5_X6, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        check_eq("mrst_rf_r0data", r0data_ro, 32'd0);
        check_eq("mrst_rf_r1data", r1data_ro, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
